// File: rtl/uart_pkg.sv
// Shared UART constants and helpers.
package uart_pkg;

    localparam int UART_DATA_WIDTH    = 8;
    localparam int UART_TX_FIFO_DEPTH = 16;

    // Difference of two wrap-bit pointers, modulo 2^w (w = ADDR_WIDTH+1).
    function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read.
// Contents are not reset. Shared by the TX and (later) RX FIFOs.
module uart_fifo_ram #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// AXI4-Stream byte FIFO feeding the UART transmitter (first-word-fall-through).
// Optional macro UART_TX_FIFO_THRESH_EN adds almost_full_thresh / almost_full.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = UART_DATA_WIDTH,
    parameter  int DEPTH      = UART_TX_FIFO_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
`ifdef UART_TX_FIFO_THRESH_EN
    input  logic [ADDR_WIDTH:0]   almost_full_thresh,
    output logic                  almost_full,
`endif
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic          push, pop, full_nxt;

    assign push = s_axis_tvalid && s_axis_tready;
    assign pop  = m_axis_tvalid && m_axis_tready;

    // Next pointers: flush overrides and discards any same-cycle push/pop.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PW'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);
        end
    end

    assign count_nxt = PW'(ptr_diff(32'(wr_ptr_nxt), 32'(rd_ptr_nxt), PW));
    assign full_nxt  = (count_nxt == PW'(DEPTH));

    // Pointer and registered handshake state; tready looks one state ahead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            s_axis_tready <= !full_nxt;
        end
    end

`ifdef UART_TX_FIFO_THRESH_EN
    // Registered threshold flag, computed from the next-state fill level.
    always_ff @(posedge clk) begin
        if (!rst) almost_full <= 1'b0;
        else      almost_full <= (count_nxt >= almost_full_thresh);
    end
`endif

    uart_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (s_axis_tdata),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (m_axis_tdata)
    );

    assign count         = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PW));
    assign empty         = (wr_ptr == rd_ptr);
    assign full          = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                           (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign m_axis_tvalid = !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised + directed bench for uart_tx_fifo against a queue-based model.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DW    = UART_DATA_WIDTH;
    localparam int DEPTH = UART_TX_FIFO_DEPTH;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst, flush, s_axis_tvalid, s_axis_tready;
    logic          m_axis_tvalid, m_axis_tready, full, empty;
    logic [DW-1:0] s_axis_tdata, m_axis_tdata;
    logic [AW:0]   count;
`ifdef UART_TX_FIFO_THRESH_EN
    logic [AW:0]   thresh;
    logic          almost_full;
`endif

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef UART_TX_FIFO_THRESH_EN
        .almost_full_thresh (thresh),
        .almost_full        (almost_full),
`endif
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    // Reference model: stored words, expected tready / almost_full, pop log.
    logic [DW-1:0] q[$];
    logic [DW-1:0] popped[$];
    logic          m_rdy = 1'b0;
    logic          m_af  = 1'b0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("count",    32'(count),          32'(q.size()));
        chk("empty",    32'(empty),          32'(q.size() == 0));
        chk("full",     32'(full),           32'(q.size() == DEPTH));
        chk("s_tready", 32'(s_axis_tready),  32'(m_rdy));
        chk("m_tvalid", 32'(m_axis_tvalid),  32'(q.size() != 0));
        if (q.size() != 0) chk("m_tdata", 32'(m_axis_tdata), 32'(q[0]));
`ifdef UART_TX_FIFO_THRESH_EN
        chk("almost_full", 32'(almost_full), 32'(m_af));
`endif
    endtask

    // Apply the FIFO rules to the inputs seen at this rising edge.
    task automatic model_edge();
        logic do_push, do_pop;
        if (!rst) begin
            q.delete();
            m_rdy = 1'b0;
            m_af  = 1'b0;
        end else if (flush) begin
            q.delete();
            m_rdy = 1'b1;
`ifdef UART_TX_FIFO_THRESH_EN
            m_af  = (thresh == 0);
`endif
        end else begin
            do_push = s_axis_tvalid && m_rdy;
            do_pop  = m_axis_tready && (q.size() != 0);
            if (do_pop)  popped.push_back(q.pop_front());
            if (do_push) q.push_back(s_axis_tdata);
            m_rdy = (q.size() < DEPTH);
`ifdef UART_TX_FIFO_THRESH_EN
            m_af  = (q.size() >= int'(thresh));
`endif
        end
    endtask

    // One clock: check at the falling edge, drive, step model at rising edge.
    task automatic cycle(input logic r, input logic tv, input logic [DW-1:0] d,
                         input logic tr, input logic fl);
        check_outputs();
        rst           = r;
        s_axis_tvalid = tv;
        s_axis_tdata  = d;
        m_axis_tready = tr;
        flush         = fl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        int  nxt;
        logic acc;
        rst = 1'b0; flush = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        m_axis_tready = 1'b0;
`ifdef UART_TX_FIFO_THRESH_EN
        thresh = (AW+1)'(12);
`endif
        @(posedge clk); model_edge(); @(negedge clk);

        // Reset held, then released.
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("rdy_after_rst", 32'(s_axis_tready), 32'd1);
        chk("empty_after_rst", 32'(empty), 32'd1);
        chk("count_after_rst", 32'(count), 32'd0);

        // Fill with no pops, then hold a 17th word.
        popped.delete();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, DW'(i), 1'b0, 1'b0);
        chk("fill_count", 32'(count), 32'(DEPTH));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_tready", 32'(s_axis_tready), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("overflow_guard", 32'(count), 32'(DEPTH));

        // Drain while pushing 0x10..0x2F; order must survive the pointer wrap.
        nxt = 16;
        for (int c = 0; c < 300 && popped.size() < 48; c++) begin
            acc = m_rdy;
            cycle(1'b1, nxt <= 47, DW'(nxt), 1'b1, 1'b0);
            if (acc && nxt <= 47) nxt++;
        end
        chk("drain_len", 32'(popped.size()), 32'd48);
        for (int i = 0; i < 48 && i < popped.size(); i++)
            chk("drain_order", 32'(popped[i]), 32'(i));

        // Concurrent push/pop at count 5.
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, DW'(8'h70 + i), 1'b1, 1'b0);
            chk("steady_count", 32'(count), 32'd5);
        end

        // Flush at count 9 with a simultaneous push of 0x55.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd9);
        cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("flush_tready", 32'(s_axis_tready), 32'd1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("flush_no_55", 32'(m_axis_tvalid), 32'd0);

`ifdef UART_TX_FIFO_THRESH_EN
        thresh = (AW+1)'(12);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, DW'(i), 1'b0, 1'b0);
        chk("af_set", 32'(almost_full), 32'd1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("af_clear", 32'(almost_full), 32'd0);
        thresh = '0;
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("af_thresh0", 32'(almost_full), 32'd1);
        thresh = (AW+1)'(DEPTH + 1);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1, 1'b1, DW'(i), 1'b0, 1'b0);
        chk("af_above_depth", 32'(almost_full), 32'd0);
`endif

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 800; c++) begin
`ifdef UART_TX_FIFO_THRESH_EN
            if (c % 50 == 0) thresh = (AW+1)'($urandom_range(DEPTH + 1));
`endif
            cycle($urandom_range(63) != 0, $urandom_range(3) != 0, DW'($urandom),
                  $urandom_range(2) != 0, $urandom_range(31) == 0);
        end
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
